// File: rtl/alu_mdu_pkg.sv
// mdu_pkg: shared types and helpers for the RV32M multiply/divide unit.
//   mdu_op_e    : RV32M funct3 encodings as seen on the op field.
//   mdu_state_e : sequencer states of alu_mdu.
//   is_div()    : true for the four divide/remainder operations.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_div(input mdu_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: issue/result handshake between the execute stage and alu_mdu.
//   flush               : pipeline flush, aborts any operation in flight
//   in_valid / in_ready : operand handshake (op, src_a, src_b)
//   out_valid/out_ready : result handshake (result)
// master = execute stage (issuer), slave = alu_mdu.
interface alu_mdu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output flush, in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_mdu_if.slave -- flush, in_valid/in_ready/op/src_a/src_b,
//           out_valid/out_ready/result
// Multiply is radix-2 shift-add, divide is restoring, both on operand
// magnitudes over DATA_WIDTH cycles, followed by a sign-fix/select cycle.
// Divide-by-zero and signed overflow are resolved at accept time.
module alu_mdu
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_mdu_if.slave      bus
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    mdu_state_e           state_q, state_d;
    mdu_op_e              op_q;
    logic                 res_neg_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [W-1:0]         opnd_q;     // multiplicand (mul) or divisor (div) magnitude
    logic [2*W:0]         acc_q;      // product, or {remainder, quotient}
    logic [W-1:0]         result_q;
    logic                 out_valid_q;

    // ---------------- accept-time decode ----------------
    mdu_op_e      op_in;
    logic         signed_a, signed_b, neg_a, neg_b;
    logic [W-1:0] mag_a, mag_b;
    logic         div_zero, div_ovf, special, res_neg_in, accept;
    logic [W-1:0] special_val;

    always_comb begin
        op_in      = mdu_op_e'(bus.op);
        signed_a   = !(op_in inside {OP_MULHU, OP_DIVU, OP_REMU});
        signed_b   = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        neg_a      = signed_a && bus.src_a[W-1];
        neg_b      = signed_b && bus.src_b[W-1];
        mag_a      = neg_a ? -bus.src_a : bus.src_a;
        mag_b      = neg_b ? -bus.src_b : bus.src_b;
        div_zero   = (bus.src_b == '0);
        // signed_b is only set for DIV/REM among the divides
        div_ovf    = signed_b && (bus.src_a == MOST_NEG) && (bus.src_b == '1);
        special    = is_div(op_in) && (div_zero || div_ovf);
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero)
            special_val = op_in[1] ? bus.src_a : '1;
        else
            special_val = op_in[1] ? '0 : bus.src_a;
        // remainder follows the dividend sign; product and quotient use XOR
        res_neg_in = (is_div(op_in) && op_in[1]) ? neg_a : (neg_a ^ neg_b);
        accept     = (state_q == IDLE) && bus.in_valid && !bus.flush;
    end

    // ---------------- one iteration step ----------------
    logic [W:0]   mul_sum;
    logic [2*W:0] div_shift;
    logic [W+1:0] div_diff;
    logic [2*W:0] acc_step;

    always_comb begin
        // acc_q[2W] stays zero during multiply, so the W+1-bit sum cannot wrap
        mul_sum   = acc_q[2*W:W] + {1'b0, opnd_q};
        div_shift = {acc_q[2*W-1:0], 1'b0};
        div_diff  = {1'b0, div_shift[2*W:W]} - {2'b00, opnd_q};
        acc_step  = acc_q;
        if (is_div(op_q)) begin
            if (!div_diff[W+1])
                acc_step = {div_diff[W:0], div_shift[W-1:1], 1'b1};
            else
                acc_step = div_shift;
        end else begin
            if (acc_q[0])
                acc_step = {1'b0, mul_sum, acc_q[W-1:1]};
            else
                acc_step = {2'b00, acc_q[2*W-1:W], acc_q[W-1:1]};
        end
    end

    // ---------------- sign fix and result select ----------------
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s, rem_s, fix_val;

    always_comb begin
        prod_s = res_neg_q ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
        quo_s  = res_neg_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
        rem_s  = res_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        fix_val = '0;
        case (op_q)
            OP_MUL:                       fix_val = prod_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_s[2*W-1:W];
            OP_DIV, OP_DIVU:              fix_val = quo_s;
            OP_REM, OP_REMU:              fix_val = rem_s;
            default:                      fix_val = '0;
        endcase
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: if (cnt_q == CNT_WIDTH'(W - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush)
            state_d = IDLE;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            res_neg_q   <= 1'b0;
            cnt_q       <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == DONE);
            if (accept) begin
                op_q      <= op_in;
                res_neg_q <= res_neg_in;
                cnt_q     <= '0;
                if (is_div(op_in)) begin
                    opnd_q <= mag_b;
                    acc_q  <= {{(W+1){1'b0}}, mag_a};
                end else begin
                    opnd_q <= mag_a;
                    acc_q  <= {{(W+1){1'b0}}, mag_b};
                end
                if (special)
                    result_q <= special_val;
            end else if (state_q == CALC) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + 1'b1;
            end else if (state_q == FIX && !bus.flush) begin
                result_q <= fix_val;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed-vector self-checking bench for alu_mdu (DATA_WIDTH=32).
// Inputs are driven 1 ns after the rising edge, outputs sampled at that point.
module tb_alu_mdu;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mdu_if #(.DATA_WIDTH(W)) bus ();

    alu_mdu #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op       = o;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Issues one op, measures rising edges after the accept edge until out_valid
    // is seen, checks the result, then lets out_ready=1 retire it.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp,
                          input int unsigned exp_lat);
        int unsigned lat = 0;
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        issue(o, a, b);
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, bus.result, exp);
        tick();
        chk({tag, "_ret"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Counts out_valid highs over n cycles.
    task automatic watch(input int unsigned n, output int unsigned seen);
        seen = 0;
        repeat (n) begin
            tick();
            if (bus.out_valid) seen++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned seen;
        int unsigned lat;

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 3'b000;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b1;

        // reset
        tick();
        tick();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // normal ops: DONE 33 edges after the accept edge
        run_op("mul",    OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mul_lo", OP_MUL,    32'h1234_5678, 32'h10,       32'h2345_6780, 33);
        run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhu2", OP_MULHU,  32'h1234_5678, 32'h10,       32'h0000_0001, 33);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("div_nb", OP_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_nb", OP_REM,    32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_op("divu",   OP_DIVU,   32'd100,      32'd7,        32'd14,        33);
        run_op("remu",   OP_REMU,   32'd100,      32'd7,        32'd2,         33);
        run_op("divu_f", OP_DIVU,   32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 33);

        // special cases reach DONE on the accept edge itself, so out_valid is
        // already up in the first cycle after it (0 further edges)
        run_op("div0",   OP_DIV,    32'h1234,     32'd0,        32'hFFFF_FFFF, 0);
        run_op("rem0",   OP_REM,    32'h1234,     32'd0,        32'h0000_1234, 0);
        run_op("remu0",  OP_REMU,   32'd5,        32'd0,        32'd5,         0);
        run_op("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

        // flush at CALC cycle 10
        issue(OP_MUL, 32'd3, 32'd5);
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        watch(40, seen);
        chk("flush_noout", seen, 32'd0);

        // flush beats a simultaneous in_valid
        bus.op = OP_MUL; bus.src_a = 32'd2; bus.src_b = 32'd2;
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flushwin_ready", 32'(bus.in_ready), 32'd1);
        watch(40, seen);
        chk("flushwin_noout", seen, 32'd0);

        // consumer back-pressure in DONE
        bus.out_ready = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("hold_lat", lat, 32'd33);
        for (int i = 0; i < 5; i++) begin
            chk("hold_result", bus.result, 32'd14);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("release_valid", 32'(bus.out_valid), 32'd0);
        chk("release_ready", 32'(bus.in_ready), 32'd1);

        // reset mid-CALC
        issue(OP_MUL, 32'd9, 32'd9);
        repeat (5) tick();
        chk("calc_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("midrst_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_result", bus.result, 32'h0);
        rst_n = 1'b1;
        watch(40, seen);
        chk("midrst_noout", seen, 32'd0);

        // unit is usable again after the reset
        run_op("post_rst", OP_MUL, 32'd9, 32'd9, 32'd81, 33);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
